// File: rtl/ysyx22040228_clint_pkg.sv
// Shared definitions for the CLINT and the EX/MEM load-store path.
//   - Register offsets inside the 64 KiB CLINT window.
//   - funct3 width-select encodings used by load/store requests.
//   - Request/response state enum and an alignment helper.
package ysyx22040228_clint_pkg;

  localparam logic [15:0] CLINT_MSIP     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP = 16'h4000;
  localparam logic [15:0] CLINT_MTIME    = 16'hBFF8;

  // funct3 width selects; bit 2 selects zero-extension on loads, 3'b111 is illegal.
  localparam logic [2:0] SEL_B  = 3'b000;
  localparam logic [2:0] SEL_H  = 3'b001;
  localparam logic [2:0] SEL_W  = 3'b010;
  localparam logic [2:0] SEL_D  = 3'b011;
  localparam logic [2:0] SEL_BU = 3'b100;
  localparam logic [2:0] SEL_HU = 3'b101;
  localparam logic [2:0] SEL_WU = 3'b110;
  localparam logic [2:0] SEL_BAD = 3'b111;

  typedef enum logic [0:0] {StIdle, StResp} clint_state_e;

  // size: log2 of the access width in bytes; lane: low address bits.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lane);
    logic mis;
    case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = lane[0];
      2'd2:    mis = |lane[1:0];
      default: mis = |lane;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ysyx22040228_clint_if.sv
// Load/store request + registered response channel between the EX stage and
// a memory-side slave such as the CLINT.
//   master: drives req_*, rsp_ready; slave: drives req_ready, rsp_*.
interface ysyx22040228_clint_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [2:0]  req_sel;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_sel, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_sel, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ysyx22040228_lane_align.sv
// Combinational byte-lane alignment for a 64-bit data port.
//   sel_i   : funct3 width select
//   lane_i  : byte lane (addr[2:0])
//   wdata_i : right-aligned store data
//   rword_i : 64-bit word being read
//   wmask_o : bit mask of the lanes a store touches
//   wdata_o : store data shifted into its lanes
//   rdata_o : load data extracted from rword_i and extended (0 for 3'b111)
module ysyx22040228_lane_align
  import ysyx22040228_clint_pkg::*;
(
  input  logic [2:0]  sel_i,
  input  logic [2:0]  lane_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rword_i,
  output logic [63:0] wmask_o,
  output logic [63:0] wdata_o,
  output logic [63:0] rdata_o
);
  logic [63:0] size_mask;
  logic [63:0] rshift;
  logic [5:0]  shamt;

  assign shamt = {lane_i, 3'b000};

  always_comb begin
    size_mask = '1;
    unique case (sel_i[1:0])
      2'b00:   size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = '1;
    endcase
  end

  assign wmask_o = size_mask << shamt;
  assign wdata_o = (wdata_i & size_mask) << shamt;
  assign rshift  = rword_i >> shamt;

  always_comb begin
    rdata_o = '0;
    case (sel_i)
      SEL_B:   rdata_o = {{56{rshift[7]}}, rshift[7:0]};
      SEL_H:   rdata_o = {{48{rshift[15]}}, rshift[15:0]};
      SEL_W:   rdata_o = {{32{rshift[31]}}, rshift[31:0]};
      SEL_D:   rdata_o = rshift;
      SEL_BU:  rdata_o = {56'b0, rshift[7:0]};
      SEL_HU:  rdata_o = {48'b0, rshift[15:0]};
      SEL_WU:  rdata_o = {32'b0, rshift[31:0]};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/ysyx22040228_clint.sv
// Core-local interruptor: msip, mtimecmp and free-running mtime behind a
// one-outstanding load/store port with a registered response.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : request/response channel (slave side)
//   timer_intr : registered (mtime >= mtimecmp)
//   soft_intr  : msip[0]
// Build option: define YSYX22040228_CLINT_MSIP_EN to implement msip; otherwise
// offset 0x0000 faults and soft_intr is tied low.
// BASE_ADDR must be 64 KiB aligned so that offset low bits equal addr low bits.
module ysyx22040228_clint
  import ysyx22040228_clint_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx22040228_clint_if.slave  bus,
  output logic                 timer_intr,
  output logic                 soft_intr
);
  localparam int unsigned      TickW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

  clint_state_e     state_q;
  logic [63:0]      rsp_rdata_q;
  logic             rsp_err_q;
  logic [TickW-1:0] tick_cnt_q;
  logic             tick_wrap;
  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      mtimecmp_q, mtimecmp_d;
  logic             timer_intr_q;

  logic [63:0] offset;
  logic        in_window, hit_mtime, hit_mtimecmp, hit_msip;
  logic        acc_err, accept, do_write;
  logic [63:0] rd_word, wmask, wdata_sh, rdata_ext, merged;
  logic        msip_val;

  // Decode
  assign offset       = bus.req_addr - BASE_ADDR;
  assign in_window    = (offset[63:16] == 48'b0);
  assign hit_mtime    = in_window && (offset[15:3] == CLINT_MTIME[15:3]);
  assign hit_mtimecmp = in_window && (offset[15:3] == CLINT_MTIMECMP[15:3]);

  assign acc_err = (bus.req_sel == SEL_BAD)
                || is_misaligned(bus.req_sel[1:0], offset[2:0])
                || !(hit_mtime || hit_mtimecmp || hit_msip);

  assign accept   = bus.req_valid && bus.req_ready;
  assign do_write = accept && bus.req_write && !acc_err;

  always_comb begin
    rd_word = '0;
    if (hit_mtime)         rd_word = mtime_q;
    else if (hit_mtimecmp) rd_word = mtimecmp_q;
    else if (hit_msip)     rd_word = {63'b0, msip_val};
  end

  ysyx22040228_lane_align u_lane_align (
    .sel_i   (bus.req_sel),
    .lane_i  (offset[2:0]),
    .wdata_i (bus.req_wdata),
    .rword_i (rd_word),
    .wmask_o (wmask),
    .wdata_o (wdata_sh),
    .rdata_o (rdata_ext)
  );

  // Read-modify-write of the addressed register: only the stored lanes change.
  assign merged = (rd_word & ~wmask) | (wdata_sh & wmask);

`ifdef YSYX22040228_CLINT_MSIP_EN
  logic msip_q;

  assign hit_msip = in_window && (offset[15:2] == CLINT_MSIP[15:2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      msip_q <= 1'b0;
    end else if (do_write && hit_msip) begin
      msip_q <= merged[0];
    end
  end

  assign msip_val = msip_q;
`else
  assign hit_msip = 1'b0;
  assign msip_val = 1'b0;
`endif

  assign soft_intr = msip_val;

  // Timer
  assign tick_wrap = (tick_cnt_q == TickLast);

  always_comb begin
    mtime_d = tick_wrap ? mtime_q + 64'd1 : mtime_q;
    // A store in the same cycle as a tick wins; that tick is dropped.
    if (do_write && hit_mtime) mtime_d = merged;
    mtimecmp_d = mtimecmp_q;
    if (do_write && hit_mtimecmp) mtimecmp_d = merged;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q   <= '0;
      mtime_q      <= '0;
      mtimecmp_q   <= '1;
      timer_intr_q <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_wrap ? '0 : tick_cnt_q + TickW'(1);
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      timer_intr_q <= (mtime_q >= mtimecmp_q);
    end
  end

  assign timer_intr = timer_intr_q;

  // Request/response FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      state_q     <= StResp;
      rsp_rdata_q <= (bus.req_write || acc_err) ? 64'b0 : rdata_ext;
      rsp_err_q   <= acc_err;
    end else if ((state_q == StResp) && bus.rsp_ready) begin
      state_q     <= StIdle;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end
  end

  assign bus.req_ready = (state_q == StIdle) || bus.rsp_ready;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: doc/ysyx22040228_clint.md
# ysyx22040228_clint

Core-local interruptor (CLINT) that sits on the data-memory side of the pipeline. It answers the load/store requests the execute stage issues as an address plus a funct3 width select, and it drives the `timer_intr` level that the execute stage's CSR logic turns into a machine-timer trap. It holds `msip`, `mtimecmp` and a free-running `mtime`, and serves one outstanding request at a time with a registered response.

## Interface
Parameters:
- `BASE_ADDR`, default 64'h0000_0000_0200_0000: base of the 64 KiB CLINT window.
- `TICK_DIV`, default 1: number of `clk` cycles per `mtime` increment. Must be at least 1.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 64: byte address, same form as the EX stage's load/store address.
- `req_sel` in 3: funct3 encoding. 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu. 111 is illegal.
- `req_wdata` in 64: store data, right-aligned (bit 0 = LSB of the stored item).
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out 64: load result, already extended. 0 on stores and on errors.
- `rsp_err` out 1: access fault.
- `timer_intr` out 1: registered (`mtime >= mtimecmp`), unsigned compare.
- `soft_intr` out 1: `msip[0]`.

## Operation
Register map, by offset = `req_addr - BASE_ADDR`:
- `msip`: offset 0x0000, 32 bits. Only bit 0 is implemented; bits 31:1 read 0.
- `mtimecmp`: offset 0x4000, 64 bits.
- `mtime`: offset 0xBFF8, 64 bits.

Address decode and access checks:
- An access hits a register when the offset lies in [reg, reg+8) for the 64-bit registers, or [0, 4) for `msip`.
- Misaligned accesses (address not a multiple of the access size) set `rsp_err`.
- Accesses to any other offset, outside the window, or with `req_sel`=111 set `rsp_err`.
- An erroring access has no side effects.

Stores:
- A sub-word store merges only the addressed byte lanes, at lane `addr[2:0]`.
- Width field `req_sel[1:0]` sets the size. Bit 2 is ignored for stores.

Loads:
- Extract the lane at `addr[2:0]`.
- Sign-extend for b/h/w; zero-extend for bu/hu/wu/d.
- The value is captured in the accept cycle.

Prescaler and `mtime`:
- `tick_cnt` counts from 0 to `TICK_DIV-1`. `mtime` increments on the cycle the count wraps, and wraps from 2^64-1 to 0.
- When a store to `mtime` and an increment fall in the same cycle, the store wins and the increment is lost. `tick_cnt` continues unaffected.
- A store to `mtimecmp` takes effect on the compare the following cycle.

State machine, 2 states:
- IDLE: `req_ready`=1. On `req_valid`, perform the access and go to RESP.
- RESP: `rsp_valid`=1, response held stable. If `rsp_ready`=1, `req_ready`=1 as well (back-to-back). A new request accepted here stays in RESP; otherwise go to IDLE.

## Timing
- Reset values: `mtime`=0, `mtimecmp`=all-ones, `msip`=0, `tick_cnt`=0, state IDLE.
- Reset output levels: `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `timer_intr`=0, `soft_intr`=0, `req_ready`=1 from the first cycle after reset.
- Latency: a request accepted at edge N produces `rsp_valid` from edge N+1 onward. Register writes commit at edge N.
- Throughput: 1 request per cycle while `rsp_ready` stays high.
- `timer_intr` rises 1 cycle after `mtime` reaches `mtimecmp`, and falls 1 cycle after a `mtimecmp` store makes the compare false.
- `rst` asserted mid-transaction drops the pending response and any store not yet committed at that edge; all state returns to reset values.
- `mtime` keeps counting while a response is stalled.

## Configuration
- `YSYX22040228_CLINT_MSIP_EN` defined: `msip` is implemented as above and `soft_intr` follows `msip[0]`.
- Not defined: no `msip` flop, offset 0x0000 returns `rsp_err`, `soft_intr` is tied 0.

## Structure
Shared package `ysyx22040228_clint_pkg` holds:
- the offsets `CLINT_MSIP`, `CLINT_MTIMECMP`, `CLINT_MTIME`;
- the funct3 width-select constants, shared with the EX and MEM stages;
- the state enum.

One sub-module is natural: `ysyx22040228_lane_align`, combinational. It does store lane merge (write mask plus shifted data) and load extract/extend, and is reusable by the data-memory port.

## Test plan
- Reset, then idle 10 cycles with `TICK_DIV`=1 → `mtime` reads 64'd10 (±0 relative to the read's accept cycle); `timer_intr`=0.
- Store d 64'd20 to `mtimecmp` at `mtime`=15 → `timer_intr` rises exactly 1 cycle after `mtime`=20. Then store all-ones → `timer_intr` drops 1 cycle later.
- Store b 8'h80 at 0xBFF9, then load b at 0xBFF9 → `rsp_rdata`=64'hFFFF_FFFF_FFFF_FF80. Load bu → 64'h80. Other `mtime` bytes are unchanged apart from counting.
- Load w at 0x4002 → `rsp_err`=1, `rsp_rdata`=0, no state change. Load at offset 0x8000 → `rsp_err`=1.
- Store w 1 to `msip` → `soft_intr`=1 the next cycle with the macro defined. With the macro undefined, `rsp_err`=1 and `soft_intr`=0.
- Hold `rsp_ready`=0 for 3 cycles with `req_valid` high → `req_ready`=0 and response stable. Raise `rsp_ready` → the next request is accepted the same cycle and its response appears the next cycle.
